// File: rtl/pll_cfg_loader_if.sv
// rtl/pll_cfg_loader_if.sv - slave SPI link feeding the PLL configuration loader
interface pll_cfg_loader_if;
  logic sclk;
  logic mosi;
  logic ss_n;

  modport master (output sclk, output mosi, output ss_n);
  modport slave  (input  sclk, input  mosi, input  ss_n);
endinterface

// File: rtl/pll_cfg_loader.sv
// rtl/pll_cfg_loader.sv - SPI-framed shadow registers with per-channel PLL relock sequencer
// Frames are checked on ss_n release; a valid frame runs disable/apply/settle/enable/lock.
module pll_cfg_loader #(
  parameter int DATA_WIDTH   = 512,
  parameter int NUM_CH       = 2,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  pll_cfg_loader_if.slave                spi,
  input  logic [NUM_CH-1:0]              lock_i,
  input  logic                           status_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0]   cfg_o,
  output logic [NUM_CH-1:0]              pllen_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [3:0]                     status_o
);

  localparam int FRAME_LEN = 8 + DATA_WIDTH;
  localparam int CNT_MAX   = FRAME_LEN + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_DISABLE, S_APPLY, S_SETTLE, S_ENABLE, S_WAIT_LOCK
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [2:0]             sclk_q;
  logic [2:0]             ss_q;
  logic [1:0]             mosi_q;
  logic [NUM_CH-1:0]      lock_meta_q, lock_sync_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [FRAME_LEN-1:0]   rx_q;
  logic [DATA_WIDTH-1:0]  shadow_q [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] cfg_q;
  logic [NUM_CH-1:0]      pllen_q;
  logic [CH_W-1:0]        ch_q;
  logic                   done_q, done_d;
  logic [3:0]             status_q, status_d;

  logic sclk_rise, ss_fall, ss_rise, shift_en;
  logic is_short, is_long, frame_ok, start;
  logic [1:0] frame_op;
  logic [4:0] frame_ch;
  logic apply_en, enable_en, ok_set, to_set;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign shift_en  = sclk_rise & ~ss_q[1];

  // The header sits at the top of the shift register only when a full payload followed it.
  assign is_short = (bit_cnt_q == CNT_W'(8));
  assign is_long  = (bit_cnt_q == CNT_W'(FRAME_LEN));
  assign frame_op = is_short ? rx_q[7:6] : rx_q[FRAME_LEN-1 -: 2];
  assign frame_ch = is_short ? rx_q[4:0] : rx_q[FRAME_LEN-4 -: 5];
  assign frame_ok = ({27'd0, frame_ch} < 32'(NUM_CH)) &&
                    ((is_short && frame_op == 2'b11) || (is_long && frame_op == 2'b01));
  assign start    = ss_rise & frame_ok & (state_q == S_IDLE);

  // ss_n resets to its idle-high level so leaving reset is not mistaken for a frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '0;
      ss_q        <= '1;
      mosi_q      <= '0;
      lock_meta_q <= '0;
      lock_sync_q <= '0;
    end else begin
      sclk_q      <= {sclk_q[1:0], spi.sclk};
      ss_q        <= {ss_q[1:0], spi.ss_n};
      mosi_q      <= {mosi_q[0], spi.mosi};
      lock_meta_q <= lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else begin
      if (ss_fall) begin
        bit_cnt_q <= '0;
      end else if (shift_en && bit_cnt_q != CNT_W'(CNT_MAX)) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_en) begin
        rx_q <= {rx_q[FRAME_LEN-2:0], mosi_q[1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    apply_en  = 1'b0;
    enable_en = 1'b0;
    done_d    = 1'b0;
    ok_set    = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DISABLE;
          timer_d = '0;
        end
      end
      S_DISABLE: begin
        if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          state_d = S_APPLY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_APPLY: begin
        apply_en = 1'b1;
        state_d  = S_SETTLE;
        timer_d  = '0;
      end
      S_SETTLE: begin
        if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          state_d = S_ENABLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ENABLE: begin
        enable_en = 1'b1;
        state_d   = S_WAIT_LOCK;
        timer_d   = '0;
      end
      S_WAIT_LOCK: begin
        if (lock_sync_q[ch_q]) begin
          done_d  = 1'b1;
          ok_set  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          done_d  = 1'b1;
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set events are applied after the clear so a coincident set survives.
  always_comb begin
    status_d = status_clr ? 4'b0000 : status_q;
    if (ss_rise && !frame_ok)                     status_d[0] = 1'b1;
    if (ss_rise && frame_ok && state_q != S_IDLE) status_d[1] = 1'b1;
    if (to_set) begin
      status_d[2] = 1'b1;
      status_d[3] = 1'b0;
    end
    if (ok_set) status_d[3] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= '0;
      end
      cfg_q    <= '0;
      pllen_q  <= '0;
      ch_q     <= '0;
      done_q   <= 1'b0;
      status_q <= '0;
    end else begin
      if (start) begin
        ch_q <= frame_ch[CH_W-1:0];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (start && is_long && frame_ch == 5'(c)) begin
          shadow_q[c] <= rx_q[DATA_WIDTH-1:0];
        end
        if (start && frame_ch == 5'(c)) begin
          pllen_q[c] <= 1'b0;
        end
        if (apply_en && ch_q == CH_W'(c)) begin
          cfg_q[c*DATA_WIDTH +: DATA_WIDTH] <= shadow_q[c];
        end
        if (enable_en && ch_q == CH_W'(c)) begin
          pllen_q[c] <= 1'b1;
        end
      end
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign cfg_o    = cfg_q;
  assign pllen_o  = pllen_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign status_o = status_q;

endmodule
